dsp_result_capture: RTL and testbench

- Sits at the output end of the DSP48A1 slice datapath.
- Tracks an "issue" token through a programmable pipeline latency that matches the enabled register stages. The token advances only on pipe_ce cycles, exactly as the slice's own register stages do.
- On token arrival, captures P and CARRYOUT into a small first-word-fall-through FIFO and presents the results downstream on a valid/ready handshake.
- Provides credit (issue_ok) so upstream never overruns the FIFO, plus a sticky overflow flag for misuse.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/dsp_result_capture_fifo.sv | 72 +++++++
 rtl/dsp_result_capture.sv | 101 ++++++++++
 tb/tb_dsp_result_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and helpers for the DSP48A1 result-capture block.
package dsp_pkg;

  localparam int MAX_LATENCY = 8;
  localparam int P_WIDTH     = 48;

  typedef struct packed {
    logic               carry;
    logic [P_WIDTH-1:0] p;
  } result_t;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_result_capture_fifo.sv
// First-word-fall-through FIFO; the head entry is held in its own register.
module sync_fifo_fwft
  import dsp_pkg::*;
#(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [clog2_min1(DEPTH):0]   count
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_next  = rd_ptr_q + 1'b1;
    rd_ptr_d = pop_ok  ? rd_next : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head_d   = head_q;
    // Head tracks the entry at rd_ptr; a lone entry being popped is replaced by the incoming word.
    if (empty) begin
      if (push_ok) head_d = din;
    end else if (pop_ok) begin
      if (count_q == CW'(1)) begin
        if (push_ok) head_d = din;
      end else begin
        head_d = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/dsp_result_capture.sv
// Tracks issued operations through the slice pipeline and captures P/CARRYOUT on arrival.
module dsp_result_capture
  import dsp_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_ce,
  input  logic                       issue,
  input  logic [WIDTH-1:0]           p_in,
  input  logic                       carry_in,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic [$clog2(DEPTH):0]     count,
  output logic [3:0]                 in_flight,
  output logic                       issue_ok,
  output logic                       full,
  output logic                       overflow
);

  logic       arrival, capture, issue_acc;
  logic       push, pop, drop, fifo_empty;
  logic [3:0] in_flight_q, in_flight_d;
  logic       overflow_q, overflow_d;
  logic [5:0] credit_used;
  logic [WIDTH:0] fifo_dout;

  if (LATENCY == 0) begin : g_tok_none
    assign arrival = issue;
  end else begin : g_tok
    logic [LATENCY-1:0] tok_q, tok_d;

    // Token moves only with the slice's own register enable.
    always_comb begin
      tok_d = tok_q;
      if (pipe_ce) tok_d = (tok_q << 1) | LATENCY'(issue);
    end

    always_ff @(posedge clk) begin
      if (rst) tok_q <= '0;
      else     tok_q <= tok_d;
    end

    assign arrival = tok_q[LATENCY-1];
  end

  assign issue_acc = issue & pipe_ce;
  assign capture   = arrival & pipe_ce;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_comb begin
    in_flight_d = in_flight_q + 4'(issue_acc) - 4'(capture);
    overflow_d  = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({carry_in, p_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
  );

  // Credit counts results still in the slice so the FIFO can always absorb them.
  assign credit_used = 6'(count) + 6'(in_flight_q);
  assign issue_ok    = (credit_used < 6'(DEPTH));

  assign out_data  = fifo_dout[WIDTH-1:0];
  assign out_carry = fifo_dout[WIDTH];
  assign in_flight = in_flight_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Directed bench for dsp_result_capture (LATENCY=4 and LATENCY=0 instances).
module tb_dsp_result_capture;
  import dsp_pkg::*;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pipe_ce = 1'b0;
  logic         issue = 1'b0;
  logic [W-1:0] p_in = '0;
  logic         carry_in = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_ovf = 1'b0;

  logic         out_valid, out_carry, issue_ok, full, overflow;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic [3:0]   in_flight;

  logic         z_out_valid, z_out_carry, z_issue_ok, z_full, z_overflow;
  logic [W-1:0] z_out_data;
  logic [2:0]   z_count;
  logic [3:0]   z_in_flight;

  int vectors = 0;
  int miscompares = 0;
  int n_acc;
  result_t exp_r;

  always #5 clk = ~clk;

  dsp_result_capture #(.WIDTH(W), .LATENCY(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pipe_ce(pipe_ce), .issue(issue), .p_in(p_in),
    .carry_in(carry_in), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_data(out_data), .out_carry(out_carry),
    .count(count), .in_flight(in_flight), .issue_ok(issue_ok), .full(full),
    .overflow(overflow)
  );

  dsp_result_capture #(.WIDTH(W), .LATENCY(0), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .pipe_ce(pipe_ce), .issue(issue), .p_in(p_in),
    .carry_in(carry_in), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_carry(z_out_carry),
    .count(z_count), .in_flight(z_in_flight), .issue_ok(z_issue_ok), .full(z_full),
    .overflow(z_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_full", full, 0);
    chk("rst_issue_ok", issue_ok, 1);
    chk("rst_count", count, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_overflow", overflow, 0);

    // Single issue, continuous CE: capture 4 edges later.
    pipe_ce = 1'b1;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("t1_inflight_a", in_flight, 1);
    tick();
    tick();
    p_in = 48'h0000_1234_5678;
    tick();
    chk("t1_inflight_b", in_flight, 1);
    chk("t1_not_valid_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 48'h0000_1234_5678);
    chk("t1_inflight_c", in_flight, 0);
    chk("t1_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_popped", count, 0);

    // CE stalled for 5 edges while the token is at stage 1.
    issue = 1'b1;
    tick();
    issue = 1'b0;
    tick();
    pipe_ce = 1'b0;
    p_in = 48'h0000_0000_0ABC;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_stall_inflight", in_flight, 1);
    chk("t2_stall_count", count, 0);
    pipe_ce = 1'b1;
    tick();
    tick();
    chk("t2_before_count", count, 0);
    chk("t2_before_inflight", in_flight, 1);
    tick();
    chk("t2_count", count, 1);
    chk("t2_data", out_data, 48'h0000_0000_0ABC);
    chk("t2_inflight", in_flight, 0);
    tick();
    chk("t2_once", count, 1);

    // Fill using credit only.
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      p_in = W'(100 + i);
      issue = issue_ok;
      if (issue_ok) n_acc++;
      tick();
    end
    issue = 1'b0;
    chk("t3_accepted", n_acc, 4);
    chk("t3_count", count, 4);
    chk("t3_full", full, 1);
    chk("t3_issue_ok", issue_ok, 0);
    chk("t3_overflow", overflow, 0);
    chk("t3_head", out_data, 104);

    // Forced issue into a full FIFO.
    p_in = W'(200);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_ovf_before", overflow, 0);
    tick();
    chk("t3_ovf_set", overflow, 1);
    chk("t3_ovf_count", count, 4);
    chk("t3_ovf_head", out_data, 104);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // Capture coinciding with a pop on a full FIFO.
    issue = 1'b1;
    tick();
    issue = 1'b0;
    tick();
    tick();
    tick();
    p_in = W'(300);
    carry_in = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    carry_in = 1'b0;
    chk("t4_count", count, 4);
    chk("t4_full", full, 1);
    chk("t4_head", out_data, 105);
    chk("t4_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      exp_r.p = (i == 3) ? W'(300) : W'(105 + i);
      exp_r.carry = (i == 3);
      chk($sformatf("t4_drain%0d", i), {out_carry, out_data}, exp_r);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("t4_empty_count", count, 0);
    chk("t4_empty_valid", out_valid, 0);

    // Zero-latency instance.
    do_reset();
    issue = 1'b1;
    p_in = W'(1);
    tick();
    chk("t5_inflight_a", z_in_flight, 0);
    p_in = W'(2);
    tick();
    chk("t5_inflight_b", z_in_flight, 0);
    p_in = W'(3);
    tick();
    issue = 1'b0;
    chk("t5_inflight_c", z_in_flight, 0);
    chk("t5_count", z_count, 3);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("t5_pop%0d", i), z_out_data, i);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("t5_empty", z_out_valid, 0);

    // Reset with results queued and tokens in flight.
    do_reset();
    p_in = W'(55);
    issue = 1'b1;
    tick();
    tick();
    issue = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    issue = 1'b1;
    tick();
    tick();
    tick();
    issue = 1'b0;
    chk("t6_pre_count", count, 2);
    chk("t6_pre_inflight", in_flight, 3);
    do_reset();
    chk("t6_count", count, 0);
    chk("t6_inflight", in_flight, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_issue_ok", issue_ok, 1);
    chk("t6_data", out_data, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_ghost_count", count, 0);
    chk("t6_no_ghost_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
